// File: rtl/quantizer_block.sv
// FP32 -> signed 32-bit quantization level: round(value * INV_STEP), 4-stage pipeline
// with a global stall driven by downstream backpressure.
module quantizer_block #(
  parameter logic [31:0] INV_STEP_W = 32'h442AAAAB,
  parameter logic [31:0] INV_STEP_A = 32'h48CCCCCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value_fp,
  input  logic        is_weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] level_int,
  output logic        ovfl_reg,
  output logic        unfl_reg,
  output logic        excp_reg
);

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // S1: unpack operand and selected reciprocal step
  logic [31:0] step_sel;
  assign step_sel = is_weight ? INV_STEP_W : INV_STEP_A;

  logic        v1_q, sa1_q, sb1_q, zero1_q, exc1_q;
  logic [7:0]  ea1_q, eb1_q;
  logic [23:0] ma1_q, mb1_q;

  // S2: mantissa product and exponent sum
  logic               v2_q, s2_q, zero2_q, exc2_q;
  logic signed [9:0]  e2_q, e2_d;
  logic [47:0]        p2_q;

  assign e2_d = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - 10'sd127;

  // S3: normalise and round product mantissa to 24 bits, nearest-even
  logic               v3_q, s3_q, zero3_q, exc3_q;
  logic signed [9:0]  e3_q, e3_d;
  logic [23:0]        m3_q, m3_d, norm_m;
  logic               g3, st3, rnd3;
  logic [24:0]        m25;

  always_comb begin
    norm_m = p2_q[47] ? p2_q[47:24] : p2_q[46:23];
    g3     = p2_q[47] ? p2_q[23]    : p2_q[22];
    st3    = p2_q[47] ? |p2_q[22:0] : |p2_q[21:0];
    rnd3   = g3 & (st3 | norm_m[0]);
    m25    = {1'b0, norm_m} + 25'(rnd3);
    m3_d   = m25[24] ? m25[24:1] : m25[23:0];
    e3_d   = e2_q + 10'(p2_q[47]) + 10'(m25[24]);
  end

  // S4: float -> integer, round half away from zero, saturate
  logic              v4_q, ovfl_q, unfl_q, excp_q;
  logic [31:0]       level_q, level_d, h4, mag4;
  logic              ovfl_d, unfl_d, excp_d;
  logic signed [9:0] eu4;
  logic [4:0]        sh4;

  always_comb begin
    eu4 = e3_q - 10'sd127;
    // sh4 = eu4+1; the value is m3 * 2^(sh4-24), so h4 = floor(2*|value|)
    sh4  = eu4[4:0] + 5'd1;
    h4   = 32'(({31'd0, m3_q} << sh4) >> 23);
    mag4 = 32'(({1'b0, h4} + 33'd1) >> 1);
    level_d = 32'd0;
    ovfl_d  = 1'b0;
    unfl_d  = 1'b0;
    excp_d  = 1'b0;
    if (exc3_q) begin
      excp_d = 1'b1;
    end else if (zero3_q) begin
      level_d = 32'd0;
    end else if (eu4 >= 10'sd31) begin
      if (s3_q && eu4 == 10'sd31 && m3_q == 24'h800000) begin
        level_d = 32'h8000_0000;
      end else begin
        ovfl_d  = 1'b1;
        level_d = s3_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (eu4 < -10'sd1) begin
      unfl_d = 1'b1;
    end else if (mag4[31]) begin
      ovfl_d  = 1'b1;
      level_d = s3_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      level_d = s3_q ? (~mag4 + 32'd1) : mag4;
      unfl_d  = (mag4 == 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; sa1_q <= 1'b0; sb1_q <= 1'b0; zero1_q <= 1'b0; exc1_q <= 1'b0;
      ea1_q <= '0; eb1_q <= '0; ma1_q <= '0; mb1_q <= '0;
      v2_q <= 1'b0; s2_q <= 1'b0; zero2_q <= 1'b0; exc2_q <= 1'b0;
      e2_q <= '0; p2_q <= '0;
      v3_q <= 1'b0; s3_q <= 1'b0; zero3_q <= 1'b0; exc3_q <= 1'b0;
      e3_q <= '0; m3_q <= '0;
      v4_q <= 1'b0; level_q <= '0; ovfl_q <= 1'b0; unfl_q <= 1'b0; excp_q <= 1'b0;
    end else if (adv) begin
      v1_q    <= in_valid;
      sa1_q   <= value_fp[31];
      ea1_q   <= value_fp[30:23];
      ma1_q   <= {1'b1, value_fp[22:0]};
      sb1_q   <= step_sel[31];
      eb1_q   <= step_sel[30:23];
      mb1_q   <= {1'b1, step_sel[22:0]};
      zero1_q <= (value_fp[30:23] == 8'd0);
      exc1_q  <= (value_fp[30:23] == 8'hFF);

      v2_q    <= v1_q;
      s2_q    <= sa1_q ^ sb1_q;
      e2_q    <= e2_d;
      p2_q    <= ma1_q * mb1_q;
      zero2_q <= zero1_q;
      exc2_q  <= exc1_q;

      v3_q    <= v2_q;
      s3_q    <= s2_q;
      e3_q    <= e3_d;
      m3_q    <= m3_d;
      zero3_q <= zero2_q;
      exc3_q  <= exc2_q;

      v4_q    <= v3_q;
      level_q <= level_d;
      ovfl_q  <= ovfl_d;
      unfl_q  <= unfl_d;
      excp_q  <= excp_d;
    end
  end

  assign out_valid = v4_q;
  assign level_int = level_q;
  assign ovfl_reg  = ovfl_q;
  assign unfl_reg  = unfl_q;
  assign excp_reg  = excp_q;

endmodule

// File: tb/tb_quantizer_block.sv
// Directed bench for quantizer_block: reset, nominal, zero/underflow, saturation,
// backpressure ordering/stability and a dequantize->quantize round trip.
module tb_quantizer_block;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value_fp;
  logic        is_weight;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] level_int;
  logic        ovfl_reg, unfl_reg, excp_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quantizer_block dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value_fp  (value_fp),
    .is_weight (is_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level_int (level_int),
    .ovfl_reg  (ovfl_reg),
    .unfl_reg  (unfl_reg),
    .excp_reg  (excp_reg)
  );

  // Sends one value into an idle pipeline and waits (bounded) for its result.
  task automatic send_one(input logic [31:0] v, input logic w,
                          output logic [31:0] lvl, output logic [2:0] fl, output int lat);
    @(negedge clk);
    in_valid = 1'b1; value_fp = v; is_weight = w; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    lvl = level_int;
    fl  = {ovfl_reg, unfl_reg, excp_reg};
  endtask

  // Exact FP32 encoding of L * 0.00146484375 (= L*3/2048).
  function automatic logic [31:0] lvl_to_fp(input int l);
    int unsigned v;
    int          p;
    logic [31:0] r;
    v = (l < 0) ? -l : l;
    v = v * 3;
    if (v == 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 32; b++) if (v[b]) p = b;
    r[31]    = (l < 0);
    r[30:23] = 8'(p - 11 + 127);
    r[22:0]  = 23'(v << (23 - p));
    return r;
  endfunction

  task automatic test_reset_state;
    rst = 1'b0; in_valid = 1'b0; value_fp = '0; is_weight = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level_int !== 32'd0 || {ovfl_reg, unfl_reg, excp_reg} !== 3'b000)
      $display("FAIL reset_state got valid=%b level=%h flags=%b want 0/0/000",
               out_valid, level_int, {ovfl_reg, unfl_reg, excp_reg});
      else begin end
    if (out_valid !== 1'b0 || level_int !== 32'd0 || {ovfl_reg, unfl_reg, excp_reg} !== 3'b000)
      errors++;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b want 1", in_ready);
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal;
    logic [31:0] vin [3];
    logic        win [3];
    logic [31:0] exp_l [3];
    logic [31:0] lvl;
    logic [2:0]  fl;
    int          lat;
    vin   = '{32'h40C00000, 32'h3C200000, 32'hBAC00000};
    win   = '{1'b1, 1'b0, 1'b1};
    exp_l = '{32'd4096, 32'd4096, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      send_one(vin[i], win[i], lvl, fl, lat);
      checks++;
      if (lvl !== exp_l[i] || fl !== 3'b000) begin
        $display("FAIL nominal[%0d] got level=%h flags=%b want level=%h flags=000",
                 i, lvl, fl, exp_l[i]);
        errors++;
      end
      checks++;
      if (lat !== 4) begin
        $display("FAIL nominal_latency[%0d] got %0d want 4", i, lat);
        errors++;
      end
    end
  endtask

  task automatic test_zero_underflow;
    logic [31:0] vin [5];
    logic [2:0]  exp_f [5];
    logic [31:0] lvl;
    logic [2:0]  fl;
    int          lat;
    vin   = '{32'h00000000, 32'h80000001, 32'h39800000, 32'h80000000, 32'hB9800000};
    exp_f = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b010};
    for (int i = 0; i < 5; i++) begin
      send_one(vin[i], 1'b1, lvl, fl, lat);
      checks++;
      if (lat > 4 || lvl !== 32'd0 || fl !== exp_f[i]) begin
        $display("FAIL zero_unfl[%0d] got level=%h flags=%b lat=%0d want level=0 flags=%b",
                 i, lvl, fl, lat, exp_f[i]);
        errors++;
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] vin [5];
    logic [31:0] exp_l [5];
    logic [2:0]  exp_f [5];
    logic [31:0] lvl;
    logic [2:0]  fl;
    int          lat;
    vin   = '{32'h7F000000, 32'hFF000000, 32'h7FC00000, 32'h7F800000, 32'hFF800000};
    exp_l = '{32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 32'd0};
    exp_f = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001};
    for (int i = 0; i < 5; i++) begin
      send_one(vin[i], 1'b1, lvl, fl, lat);
      checks++;
      if (lat > 4 || lvl !== exp_l[i] || fl !== exp_f[i]) begin
        $display("FAIL saturate[%0d] got level=%h flags=%b lat=%0d want level=%h flags=%b",
                 i, lvl, fl, lat, exp_l[i], exp_f[i]);
        errors++;
      end
    end
  endtask

  task automatic test_reset_midflight;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; value_fp = 32'h40C00000; is_weight = 1'b1; out_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || level_int !== 32'd4096) begin
      $display("FAIL reset_prefill got valid=%b level=%h want 1/00001000", out_valid, level_int);
      errors++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level_int !== 32'd0 || {ovfl_reg, unfl_reg, excp_reg} !== 3'b000) begin
      $display("FAIL reset_async got valid=%b level=%h flags=%b want 0/0/000",
               out_valid, level_int, {ovfl_reg, unfl_reg, excp_reg});
      errors++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      $display("FAIL reset_stale got %0d stale outputs want 0", seen);
      errors++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] bv [6];
    logic        bw [6];
    logic [31:0] be [6];
    logic        pat [4];
    logic        ov, ordy, prev_hold;
    logic [31:0] lvl, prev_lvl;
    int          idx, got, extra;
    bv  = '{32'h40C00000, 32'hBAC00000, 32'h3BA00000, 32'h41400000, 32'hC0400000, 32'h3F800000};
    bw  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    be  = '{32'd4096, 32'hFFFFFFFF, 32'd2048, 32'd8192, 32'hFFFFF800, 32'd683};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx = 0; got = 0; prev_hold = 1'b0; prev_lvl = '0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      @(negedge clk);
      ov  = out_valid;
      lvl = level_int;
      if (prev_hold) begin
        checks++;
        if (ov !== 1'b1 || lvl !== prev_lvl) begin
          $display("FAIL bp_stable cycle %0d got valid=%b level=%h want 1/%h", c, ov, lvl, prev_lvl);
          errors++;
        end
      end
      ordy = pat[c % 4];
      out_ready = ordy;
      if (idx < 6) begin
        in_valid = 1'b1; value_fp = bv[idx]; is_weight = bw[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== (!ov | ordy)) begin
        $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, (!ov | ordy));
        errors++;
      end
      if (in_valid && in_ready) idx++;
      if (ov && ordy) begin
        checks++;
        if (lvl !== be[got]) begin
          $display("FAIL bp_order[%0d] got %h want %h", got, lvl, be[got]);
          errors++;
        end
        got++;
      end
      prev_hold = ov && !ordy;
      prev_lvl  = lvl;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 6) begin
      $display("FAIL bp_count got %0d outputs want 6", got);
      errors++;
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      $display("FAIL bp_duplicate got %0d extra outputs want 0", extra);
      errors++;
    end
  endtask

  task automatic test_round_trip;
    int L [100];
    int idx, got;
    for (int i = 0; i < 100; i++) L[i] = int'($urandom_range(40000)) - 20000;
    L[0] = 20000; L[1] = -20000; L[2] = 0; L[3] = 1; L[4] = -1;
    idx = 0; got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (level_int !== L[got] || {ovfl_reg, unfl_reg, excp_reg} !== 3'b000) begin
          $display("FAIL round_trip[%0d] got level=%0d flags=%b want level=%0d flags=000",
                   got, $signed(level_int), {ovfl_reg, unfl_reg, excp_reg}, L[got]);
          errors++;
        end
        got++;
      end
      if (idx < 100) begin
        in_valid = 1'b1; value_fp = lvl_to_fp(L[idx]); is_weight = 1'b1;
        idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 100) begin
      $display("FAIL round_trip_count got %0d want 100", got);
      errors++;
    end
  endtask

  initial begin
    test_reset_state();
    test_nominal();
    test_zero_underflow();
    test_saturation();
    test_reset_midflight();
    test_backpressure();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
